// File: rtl/audio_tdm_tx.sv
// -----------------------------------------------------------------------------
// audio_tdm_tx
//   Serial audio transmitter. PCM samples enter through a valid/ready stream
//   into a small FIFO and are serialised MSB first, left-justified in
//   SLOT_W-bit slots, as I2S (2 channels, mode_i=0) or TDM (NUM_CH channels,
//   mode_i=1) frames. A frame only consumes samples when a whole frame's
//   worth is queued at frame start; otherwise it sends zeros and raises a
//   sticky underrun flag.
//
// Ports
//   clk_i, rst_i          system clock, asynchronous active-low reset
//   enable_i              transmitter enable (0 aborts the current frame)
//   mode_i                0 = I2S, 1 = TDM; sampled at frame start
//   clk_div_i             SCK half-period minus 1; sampled at frame start
//   fifo_flush_i          synchronous FIFO clear, wins over a push
//   sample_valid_i/data_i sample stream in, channel order = write order
//   sample_ready_o        FIFO not full
//   fifo_level_o          occupied FIFO entries
//   i2s_sck_o/ws_o/sdata_o serial bit clock, word select / frame sync, data
//   underrun_o            sticky underrun flag, cleared by underrun_clr_i
//   intr_o                interrupt, mirrors underrun_o
// -----------------------------------------------------------------------------
module audio_tdm_tx #(
  parameter int DATA_W     = 24,
  parameter int SLOT_W     = 32,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             enable_i,
  input  logic                             mode_i,
  input  logic [DIV_W-1:0]                 clk_div_i,
  input  logic                             fifo_flush_i,
  input  logic                             sample_valid_i,
  input  logic [DATA_W-1:0]                sample_data_i,
  output logic                             sample_ready_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o,
  output logic                             i2s_sck_o,
  output logic                             i2s_ws_o,
  output logic                             i2s_sdata_o,
  output logic                             underrun_o,
  input  logic                             underrun_clr_i,
  output logic                             intr_o
);

  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int SBIT_W = $clog2(SLOT_W);
  localparam int SIDX_W = $clog2(NUM_CH);

  typedef enum logic {IDLE, RUN} state_e;

  state_e              state_q, state_d;

  // FIFO
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]    level_q;
  logic                ready_en_q;
  logic                push, pop;

  // Serialiser
  logic [DIV_W-1:0]    div_q, div_cnt_q;
  logic                sck_q, ws_q, sdata_q;
  logic [SLOT_W-1:0]   shreg_q, load_word;
  logic [SBIT_W-1:0]   slot_bit_q, slot_bit_d;
  logic [SIDX_W-1:0]   slot_idx_q, slot_idx_d, ws_slot;
  logic                mode_q, frame_ok_q, underrun_q;

  // Control decode
  logic start_idle, tc, sck_fall, last_slot_bit, last_bit;
  logic frame_start, advance, level_ok, ok_now, mode_now, slot_load, ws_d;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of process order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i)  state_d = RUN;
      RUN:     if (!enable_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: control outputs
  // NOTE: every signal gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    start_idle    = (state_q == IDLE) && enable_i;
    tc            = (div_cnt_q == div_q);
    sck_fall      = (state_q == RUN) && enable_i && tc && sck_q;
    last_slot_bit = (slot_bit_q == SBIT_W'(SLOT_W - 1));
    last_bit      = last_slot_bit && (slot_idx_q == SIDX_W'(NUM_CH - 1));
    frame_start   = start_idle || (sck_fall && last_bit);
    advance       = start_idle || sck_fall;
    level_ok      = (level_q >= LVL_W'(NUM_CH));
    ok_now        = frame_start ? level_ok : frame_ok_q;
    mode_now      = frame_start ? mode_i : mode_q;
    slot_load     = frame_start || (sck_fall && last_slot_bit);
    // An ok frame never finds the FIFO empty unless a flush intervened.
    pop           = slot_load && ok_now && (level_q != '0);

    // Position of the bit about to be presented.
    slot_bit_d = slot_bit_q + 1'b1;
    slot_idx_d = slot_idx_q;
    if (frame_start) begin
      slot_bit_d = '0;
      slot_idx_d = '0;
    end else if (last_slot_bit) begin
      slot_bit_d = '0;
      slot_idx_d = slot_idx_q + 1'b1;
    end

    // WS leads data by one bit: it reflects the slot of the following bit.
    ws_slot = slot_idx_d;
    if (slot_bit_d == SBIT_W'(SLOT_W - 1))
      ws_slot = (slot_idx_d == SIDX_W'(NUM_CH - 1)) ? '0 : slot_idx_d + 1'b1;
    if (mode_now)
      ws_d = (slot_bit_d == SBIT_W'(SLOT_W - 1)) && (slot_idx_d == SIDX_W'(NUM_CH - 1));
    else
      ws_d = ws_slot[0];

    load_word = '0;
    if (pop) load_word[SLOT_W-1 -: DATA_W] = mem[rd_ptr_q];
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  assign sample_ready_o = ready_en_q && (level_q < LVL_W'(FIFO_DEPTH));
  assign push           = sample_valid_i && sample_ready_o;
  assign fifo_level_o   = level_q;

  // NOTE: the storage array has no reset; the level and pointers alone decide
  // which entries are meaningful, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk_i) begin
    if (push && !fifo_flush_i) mem[wr_ptr_q] <= sample_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (fifo_flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({push, pop})
          2'b10:   level_q <= level_q + 1'b1;
          2'b01:   level_q <= level_q - 1'b1;
          default: level_q <= level_q;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Divider and serialiser
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      div_q      <= '0;
      div_cnt_q  <= '0;
      sck_q      <= 1'b0;
      ws_q       <= 1'b0;
      sdata_q    <= 1'b0;
      shreg_q    <= '0;
      slot_bit_q <= '0;
      slot_idx_q <= '0;
      mode_q     <= 1'b0;
      frame_ok_q <= 1'b0;
    end else if (!enable_i) begin
      // Abort: outputs low at once; samples already popped are dropped.
      div_cnt_q  <= '0;
      sck_q      <= 1'b0;
      ws_q       <= 1'b0;
      sdata_q    <= 1'b0;
      shreg_q    <= '0;
      slot_bit_q <= '0;
      slot_idx_q <= '0;
      frame_ok_q <= 1'b0;
    end else begin
      div_cnt_q <= (start_idle || tc) ? '0 : div_cnt_q + 1'b1;
      if ((state_q == RUN) && tc) sck_q <= ~sck_q;
      if (advance) begin
        slot_bit_q <= slot_bit_d;
        slot_idx_q <= slot_idx_d;
        ws_q       <= ws_d;
        if (slot_load) begin
          sdata_q <= load_word[SLOT_W-1];
          shreg_q <= {load_word[SLOT_W-2:0], 1'b0};
        end else begin
          sdata_q <= shreg_q[SLOT_W-1];
          shreg_q <= {shreg_q[SLOT_W-2:0], 1'b0};
        end
      end
      if (frame_start) begin
        div_q      <= clk_div_i;
        mode_q     <= mode_i;
        frame_ok_q <= level_ok;
      end
    end
  end

  // Sticky underrun: a same-cycle set beats the clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                        underrun_q <= 1'b0;
    else if (frame_start && !level_ok) underrun_q <= 1'b1;
    else if (underrun_clr_i)           underrun_q <= 1'b0;
  end

  assign i2s_sck_o   = sck_q;
  assign i2s_ws_o    = ws_q;
  assign i2s_sdata_o = sdata_q;
  assign underrun_o  = underrun_q;
  assign intr_o      = underrun_q;

endmodule

// File: tb/tb_audio_tdm_tx.sv
// -----------------------------------------------------------------------------
// tb_audio_tdm_tx
//   Scoreboard bench for audio_tdm_tx. Stimulus builds each expected frame
//   from a queue model of the FIFO and pushes one entry per serial bit; the
//   monitor pops an entry at every SCK rising edge and compares WS, SDATA and
//   the SCK period.
// -----------------------------------------------------------------------------
module tb_audio_tdm_tx;

  localparam int DATA_W     = 24;
  localparam int SLOT_W     = 32;
  localparam int NUM_CH     = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int DIV_W      = 8;
  localparam int FRAME_BITS = NUM_CH * SLOT_W;
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

  typedef struct {
    logic ws;
    logic sd;
    int   period;  // expected clk cycles since previous SCK rise, 0 = unchecked
  } bit_exp_t;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              enable_i = 1'b0;
  logic              mode_i = 1'b0;
  logic [DIV_W-1:0]  clk_div_i = '0;
  logic              fifo_flush_i = 1'b0;
  logic              sample_valid_i = 1'b0;
  logic [DATA_W-1:0] sample_data_i = '0;
  logic              underrun_clr_i = 1'b0;
  logic              sample_ready_o;
  logic [LVL_W-1:0]  fifo_level_o;
  logic              i2s_sck_o, i2s_ws_o, i2s_sdata_o, underrun_o, intr_o;

  audio_tdm_tx #(
    .DATA_W(DATA_W), .SLOT_W(SLOT_W), .NUM_CH(NUM_CH),
    .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .mode_i(mode_i),
    .clk_div_i(clk_div_i), .fifo_flush_i(fifo_flush_i),
    .sample_valid_i(sample_valid_i), .sample_data_i(sample_data_i),
    .sample_ready_o(sample_ready_o), .fifo_level_o(fifo_level_o),
    .i2s_sck_o(i2s_sck_o), .i2s_ws_o(i2s_ws_o), .i2s_sdata_o(i2s_sdata_o),
    .underrun_o(underrun_o), .underrun_clr_i(underrun_clr_i), .intr_o(intr_o)
  );

  always #5 clk_i = ~clk_i;

  int                n_checks = 0;
  int                n_pass   = 0;
  int                cyc      = 0;
  bit_exp_t          exp_q[$];
  logic [DATA_W-1:0] fifo_m[$];
  logic              underrun_m = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: one scoreboard entry per SCK rising edge.
  initial begin : monitor
    logic     prev_sck;
    int       last_rise;
    bit_exp_t e;
    prev_sck  = 1'b0;
    last_rise = 0;
    forever begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (i2s_sck_o === 1'b1 && prev_sck === 1'b0) begin
        check("bit_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("ws", i2s_ws_o, e.ws);
          check("sdata", i2s_sdata_o, e.sd);
          if (e.period != 0) check("sck_period", cyc - last_rise, e.period);
        end
        last_rise = cyc;
      end
      prev_sck = i2s_sck_o;
    end
  end

  // Reference model: one frame from the queued samples.
  task automatic queue_frame(input logic md, input int div, input bit first);
    logic [DATA_W-1:0] s [NUM_CH];
    bit_exp_t          e;
    int                slot, pos;
    bit                ok;
    ok = fifo_m.size() >= NUM_CH;
    if (!ok) underrun_m = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      s[c] = '0;
      if (ok) s[c] = fifo_m.pop_front();
    end
    for (int b = 0; b < FRAME_BITS; b++) begin
      slot     = b / SLOT_W;
      pos      = b % SLOT_W;
      e.sd     = (pos < DATA_W) ? s[slot][DATA_W-1-pos] : 1'b0;
      e.ws     = md ? (b == FRAME_BITS - 1) : ((((b + 1) % FRAME_BITS) / SLOT_W) == 1);
      e.period = (first && b == 0) ? 0 : 2 * (div + 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_sample(input logic [DATA_W-1:0] d);
    @(negedge clk_i);
    sample_valid_i = 1'b1;
    sample_data_i  = d;
    check("ready", sample_ready_o, fifo_m.size() < FIFO_DEPTH);
    if (fifo_m.size() < FIFO_DEPTH) fifo_m.push_back(d);
    @(posedge clk_i);
  endtask

  task automatic end_push();
    @(negedge clk_i);
    sample_valid_i = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_sck"}, i2s_sck_o, 0);
    check({tag, "_ws"}, i2s_ws_o, 0);
    check({tag, "_sdata"}, i2s_sdata_o, 0);
  endtask

  // Enables and waits (bounded) until exp_q drains to 'left' entries.
  task automatic run_until(input int left, input int div);
    int budget;
    enable_i = 1'b1;
    budget   = (exp_q.size() - left + 1) * 2 * (div + 1) + 20;
    while (exp_q.size() > left && budget > 0) begin
      @(negedge clk_i);
      budget--;
    end
    check("progress", exp_q.size(), left);
  endtask

  task automatic run_frames(input int n, input int div, input logic md);
    @(negedge clk_i);
    clk_div_i = DIV_W'(div);
    mode_i    = md;
    for (int f = 0; f < n; f++) queue_frame(md, div, f == 0);
    run_until(0, div);
    enable_i = 1'b0;
    exp_q.delete();
    @(posedge clk_i);
    #1;
    check_quiet("idle");
    check("level", fifo_level_o, fifo_m.size());
    check("underrun", underrun_o, underrun_m);
    check("intr", intr_o, underrun_m);
  endtask

  task automatic clear_underrun();
    @(negedge clk_i);
    underrun_clr_i = 1'b1;
    underrun_m     = 1'b0;
    @(posedge clk_i);
    #1;
    check("underrun_clr", underrun_o, underrun_m);
    check("intr_clr", intr_o, underrun_m);
    @(negedge clk_i);
    underrun_clr_i = 1'b0;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int   np, div, nf;
    logic md;

    // Reset state
    repeat (3) @(negedge clk_i);
    check_quiet("rst");
    check("rst_ready", sample_ready_o, 0);
    check("rst_level", fifo_level_o, 0);
    check("rst_underrun", underrun_o, 0);
    check("rst_intr", intr_o, 0);
    rst_i = 1'b1;
    #1 check("ready_after_release", sample_ready_o, 0);
    @(posedge clk_i);
    #1 check("ready_one_cycle_later", sample_ready_o, 1);

    // I2S frame of two samples, clk_div 1
    push_sample(24'hABCDEF);
    push_sample(24'h123456);
    end_push();
    check("level_two", fifo_level_o, fifo_m.size());
    run_frames(1, 1, 1'b0);

    // Underrun: one sample is not a frame's worth
    push_sample(24'h5A5A5A);
    end_push();
    run_frames(1, 1, 1'b0);
    clear_underrun();
    push_sample(24'hC3C3C3);
    end_push();
    run_frames(1, 1, 1'b0);

    // TDM framing, clk_div 0
    push_sample(24'h111111);
    push_sample(24'h222222);
    push_sample(24'h333333);
    push_sample(24'h444444);
    end_push();
    run_frames(2, 0, 1'b1);

    // Full FIFO while disabled, then flush with a simultaneous push
    for (int i = 0; i < FIFO_DEPTH + 1; i++) push_sample(DATA_W'(32'h100 + i));
    @(negedge clk_i);
    check("full_level", fifo_level_o, fifo_m.size());
    check("full_ready", sample_ready_o, fifo_m.size() < FIFO_DEPTH);
    fifo_flush_i   = 1'b1;
    sample_valid_i = 1'b1;
    @(posedge clk_i);
    fifo_m.delete();
    @(negedge clk_i);
    fifo_flush_i   = 1'b0;
    sample_valid_i = 1'b0;
    check("flush_level", fifo_level_o, fifo_m.size());

    // Disable mid-frame after bit 40, then resume from the remaining samples
    for (int i = 0; i < 4; i++) push_sample(DATA_W'($urandom));
    end_push();
    clk_div_i = 8'd1;
    mode_i    = 1'b0;
    queue_frame(1'b0, 1, 1'b1);
    run_until(FRAME_BITS - 41, 1);
    enable_i = 1'b0;
    exp_q.delete();
    @(posedge clk_i);
    #1;
    check_quiet("abort");
    check("abort_level", fifo_level_o, fifo_m.size());
    run_frames(1, 1, 1'b0);

    // Randomised frames
    for (int it = 0; it < 6; it++) begin
      np  = $urandom_range(0, 4);
      div = $urandom_range(0, 3);
      nf  = $urandom_range(1, 2);
      md  = 1'($urandom_range(0, 1));
      for (int i = 0; i < np; i++) push_sample(DATA_W'($urandom));
      end_push();
      run_frames(nf, div, md);
      if (underrun_m) clear_underrun();
    end

    // Asynchronous reset mid-frame with underrun pending
    run_frames(1, 0, 1'b0);
    push_sample(24'h0F0F0F);
    push_sample(24'hF0F0F0);
    end_push();
    clk_div_i = 8'd2;
    queue_frame(1'b0, 2, 1'b1);
    run_until(FRAME_BITS - 10, 2);
    @(posedge clk_i);
    #3 rst_i = 1'b0;
    #1;
    exp_q.delete();
    fifo_m.delete();
    underrun_m = 1'b0;
    enable_i   = 1'b0;
    check_quiet("async_rst");
    check("async_rst_level", fifo_level_o, fifo_m.size());
    check("async_rst_underrun", underrun_o, underrun_m);
    check("async_rst_intr", intr_o, underrun_m);
    check("async_rst_ready", sample_ready_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1 check("ready_after_rst", sample_ready_o, 1);
    push_sample(24'h765432);
    push_sample(24'h89ABCD);
    end_push();
    run_frames(1, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
